// File: rtl/timer_evt_pkg.sv
// Shared types and helpers for the timer event source.
package timer_evt_pkg;

   localparam int unsigned EVT_MODE_W = 3;

   typedef enum logic [EVT_MODE_W-1:0] {
      EVT_ALWAYS = 3'd0,
      EVT_HIGH   = 3'd1,
      EVT_LOW    = 3'd2,
      EVT_RISE   = 3'd3,
      EVT_FALL   = 3'd4,
      EVT_BOTH   = 3'd5
   } evt_mode_e;

   // Next event value for a mode, given the current and previous filtered levels.
   // Encodings 6 and 7 are reserved and never fire.
   function automatic logic evt_next(input logic [EVT_MODE_W-1:0] mode,
                                     input logic                  lvl,
                                     input logic                  prev);
      logic ev;
      case (mode)
         EVT_ALWAYS: ev = 1'b1;
         EVT_HIGH:   ev = lvl;
         EVT_LOW:    ev = ~lvl;
         EVT_RISE:   ev = lvl & ~prev;
         EVT_FALL:   ev = ~lvl & prev;
         EVT_BOTH:   ev = lvl ^ prev;
         default:    ev = 1'b0;
      endcase
      return ev;
   endfunction

endpackage

// File: rtl/evt_sync2.sv
// Parameterized-width two-flop synchronizer with synchronous active-high reset.
module evt_sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;

   // Two back-to-back flops per bit; free-running regardless of channel state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= d_i;
         r_s2 <= r_s1;
      end
   end

   assign q_o = r_s2;

endmodule

// File: rtl/timer_event_source.sv
// Timer event producer: synchronizes N external signals, glitch-filters the selected one,
// detects level/edge per mode and drives a registered single-cycle event pulse.
module timer_event_source
   import timer_evt_pkg::*;
#(
   parameter int unsigned N_INPUTS = 4,
   parameter int unsigned FILT_W   = 8,
   localparam int unsigned SEL_W   = $clog2(N_INPUTS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ctrl_active_i,
   input  logic                  ctrl_update_i,
   input  logic                  ctrl_rst_i,
   input  logic [SEL_W-1:0]      cfg_sel_i,
   input  logic [EVT_MODE_W-1:0] cfg_mode_i,
   input  logic [FILT_W-1:0]     cfg_filt_i,
   input  logic [N_INPUTS-1:0]   sig_i,
   output logic                  event_o,
   output logic                  level_o
);

   localparam logic [FILT_W-1:0] CntOne = FILT_W'(1);

   logic [SEL_W-1:0]      r_sel;
   logic [EVT_MODE_W-1:0] r_mode;
   logic [FILT_W-1:0]     r_filt;
   logic [FILT_W-1:0]     r_cnt;
   logic                  r_flt;
   logic                  r_prev;
   logic                  r_event;

   logic [N_INPUTS-1:0]   w_s2;
   logic [SEL_W-1:0]      w_seed_sel;
   logic                  w_x;
   logic                  w_seed;
   logic                  w_sel_chg;
   logic                  w_clear;

   evt_sync2 #(
      .WIDTH (N_INPUTS)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (sig_i),
      .q_o   (w_s2)
   );

   // An input switch reseeds from the newly selected bit so no edge spans two inputs.
   assign w_seed_sel = ctrl_update_i ? cfg_sel_i : r_sel;
   assign w_sel_chg  = ctrl_update_i & (cfg_sel_i != r_sel);
   assign w_clear    = ctrl_rst_i | ~ctrl_active_i | w_sel_chg;

   // Mux the selected synchronized bit; out-of-range selects read as 0.
   always_comb begin
      w_x    = 1'b0;
      w_seed = 1'b0;
      for (int i = 0; i < N_INPUTS; i++) begin
         if (r_sel == SEL_W'(i)) begin
            w_x = w_s2[i];
         end
         if (w_seed_sel == SEL_W'(i)) begin
            w_seed = w_s2[i];
         end
      end
   end

   // Shadow configuration, loaded only on an update strobe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sel  <= '0;
         r_mode <= '0;
         r_filt <= '0;
      end else if (ctrl_update_i) begin
         r_sel  <= cfg_sel_i;
         r_mode <= cfg_mode_i;
         r_filt <= cfg_filt_i;
      end
   end

   // Glitch filter, edge history and registered event output.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt   <= '0;
         r_flt   <= 1'b0;
         r_prev  <= 1'b0;
         r_event <= 1'b0;
      end else if (w_clear) begin
         // Track the input while idle so re-enabling never looks like an edge.
         r_cnt   <= '0;
         r_flt   <= w_seed;
         r_prev  <= w_seed;
         r_event <= 1'b0;
      end else begin
         r_event <= evt_next(r_mode, r_flt, r_prev);
         r_prev  <= r_flt;
         if (w_x == r_flt) begin
            r_cnt <= '0;
         end else if (r_cnt >= r_filt) begin
            // This is the (F+1)-th consecutive mismatch: accept the new level.
            r_flt <= w_x;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CntOne;
         end
      end
   end

   assign event_o = r_event;
   assign level_o = r_flt;

endmodule

// File: tb/tb_timer_event_source.sv
// Bench for timer_event_source: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the event source.
module tb_timer_event_source;

   localparam int unsigned N  = 4;
   localparam int unsigned FW = 8;
   localparam int unsigned SW = 2;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          ctrl_active_i = 1'b0;
   logic          ctrl_update_i = 1'b0;
   logic          ctrl_rst_i = 1'b0;
   logic [SW-1:0] cfg_sel_i = '0;
   logic [2:0]    cfg_mode_i = '0;
   logic [FW-1:0] cfg_filt_i = '0;
   logic [N-1:0]  sig_i = '0;
   logic          event_o;
   logic          level_o;

   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   timer_event_source #(
      .N_INPUTS (N),
      .FILT_W   (FW)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .ctrl_active_i (ctrl_active_i),
      .ctrl_update_i (ctrl_update_i),
      .ctrl_rst_i    (ctrl_rst_i),
      .cfg_sel_i     (cfg_sel_i),
      .cfg_mode_i    (cfg_mode_i),
      .cfg_filt_i    (cfg_filt_i),
      .sig_i         (sig_i),
      .event_o       (event_o),
      .level_o       (level_o)
   );

   // Behavioural model state: pipeline of sampled vectors, config, filtered level,
   // last level, expected event and the run of samples disagreeing with the level.
   logic [N-1:0]  m_s1 = '0;
   logic [N-1:0]  m_s2 = '0;
   int            m_sel = 0;
   int            m_mode = 0;
   int            m_filt = 0;
   logic          m_flt = 1'b0;
   logic          m_prev = 1'b0;
   logic          m_ev = 1'b0;
   bit            m_run[$];

   function automatic logic pick(input logic [N-1:0] v, input int s);
      return (s < int'(N)) ? v[s] : 1'b0;
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock using the inputs as they stand before the edge.
   task automatic model_edge();
      logic x;
      logic seed;
      if (rst_i) begin
         m_s1 = '0; m_s2 = '0; m_sel = 0; m_mode = 0; m_filt = 0;
         m_flt = 1'b0; m_prev = 1'b0; m_ev = 1'b0;
         m_run.delete();
         return;
      end
      x    = pick(m_s2, m_sel);
      seed = pick(m_s2, ctrl_update_i ? int'(cfg_sel_i) : m_sel);
      if (ctrl_rst_i || !ctrl_active_i || (ctrl_update_i && int'(cfg_sel_i) != m_sel)) begin
         m_ev = 1'b0; m_flt = seed; m_prev = seed;
         m_run.delete();
      end else begin
         case (m_mode)
            0: m_ev = 1'b1;
            1: m_ev = m_flt;
            2: m_ev = !m_flt;
            3: m_ev = m_flt && !m_prev;
            4: m_ev = !m_flt && m_prev;
            5: m_ev = m_flt != m_prev;
            default: m_ev = 1'b0;
         endcase
         m_prev = m_flt;
         if (x == m_flt) begin
            m_run.delete();
         end else begin
            m_run.push_back(x);
            if (m_run.size() >= m_filt + 1) begin
               m_flt = x;
               m_run.delete();
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = sig_i;
      if (ctrl_update_i) begin
         m_sel = int'(cfg_sel_i); m_mode = int'(cfg_mode_i); m_filt = int'(cfg_filt_i);
      end
   endtask

   // One clock: step the model, let the edge happen, then compare outputs.
   task automatic cyc();
      model_edge();
      @(posedge clk_i);
      #1;
      check("event_o", event_o, m_ev);
      check("level_o", level_o, m_flt);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic update(input int sel, input int mode, input int filt);
      cfg_sel_i = SW'(sel); cfg_mode_i = 3'(mode); cfg_filt_i = FW'(filt);
      ctrl_update_i = 1'b1;
      cyc();
      ctrl_update_i = 1'b0;
   endtask

   initial begin
      int n;
      int first;
      int second;

      // Reset with all inputs high: outputs stay low throughout.
      sig_i = 4'hF;
      rst_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("rst_event", event_o, 1'b0);
         check("rst_level", level_o, 1'b0);
      end
      rst_i = 1'b0;
      sig_i = 4'h0;
      ctrl_active_i = 1'b1;

      // Rising-edge mode, no filter, input 1: event exactly after edge k+3.
      update(1, 3, 0);
      run(5);
      sig_i[1] = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (i == 3) check("rise_lat_hi", event_o, 1'b1);
         else if (event_o) n++;
      end
      check_int("rise_single", n, 0);
      sig_i[1] = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (event_o) n++;
      end
      check_int("fall_no_event", n, 0);

      // Both edges, F=3, input 0: short glitch is swallowed.
      update(0, 5, 3);
      run(5);
      sig_i[0] = 1'b1;
      cyc();
      cyc();
      sig_i[0] = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (event_o) n++;
         if (level_o) n += 100;
      end
      check_int("glitch_filtered", n, 0);

      // Six-cycle pulse: one event per edge, each 3 cycles later than unfiltered.
      sig_i[0] = 1'b1;
      n = 0; first = -1; second = -1;
      for (int i = 0; i < 20; i++) begin
         if (i == 6) sig_i[0] = 1'b0;
         cyc();
         if (event_o) begin
            n++;
            if (first < 0) first = i;
            else second = i;
         end
      end
      check_int("pulse_events", n, 2);
      check_int("pulse_rise_at", first, 6);
      check_int("pulse_fall_at", second, 12);

      // Always mode: every active cycle is an event.
      update(0, 0, 3);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (event_o) n++;
      end
      check_int("always_count", n, 10);
      ctrl_active_i = 1'b0;
      cyc();
      check("deassert_idle", event_o, 1'b0);

      // Re-enable while the input is already high: no spurious rise.
      update(0, 3, 0);
      sig_i[0] = 1'b1;
      run(5);
      ctrl_active_i = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (event_o) n++;
      end
      check_int("reenable_no_event", n, 0);

      // Input switch from a low to a high input: no event; later rise on the new input fires.
      sig_i = 4'b0100;
      run(5);
      update(2, 3, 0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (event_o) n++;
      end
      check_int("switch_no_event", n, 0);
      check("switch_level", level_o, 1'b1);
      sig_i[2] = 1'b0;
      run(8);
      sig_i[2] = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (i == 3) check("switch_rise_lat", event_o, 1'b1);
         else if (event_o) n++;
      end
      check_int("switch_rise_single", n, 0);

      // Soft reset while the F=5 filter has counted two mismatches: nothing fires.
      sig_i = '0;
      update(0, 3, 5);
      run(8);
      sig_i[0] = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         ctrl_rst_i = (i == 4);
         cyc();
         if (event_o) n++;
      end
      ctrl_rst_i = 1'b0;
      check_int("softrst_no_event", n, 0);
      check("softrst_level", level_o, 1'b1);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         for (int b = 0; b < int'(N); b++) begin
            if ($urandom_range(0, 4) == 0) sig_i[b] = ~sig_i[b];
         end
         ctrl_update_i = ($urandom_range(0, 24) == 0);
         cfg_sel_i     = SW'($urandom_range(0, 3));
         cfg_mode_i    = 3'($urandom_range(0, 7));
         cfg_filt_i    = FW'($urandom_range(0, 4));
         ctrl_rst_i    = ($urandom_range(0, 39) == 0);
         ctrl_active_i = ($urandom_range(0, 19) != 0);
         rst_i         = ($urandom_range(0, 149) == 0);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
